// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache tag/state engine.
//  - cache_state_e  : engine FSM states
//  - write_policy_e : write-through / write-back selector
//  - repl_policy_e  : FIFO / LRU selector
//  - cache_line_t   : line state record for tools that use a fixed maximum tag width
//  - OpRead/OpWrite : trace opcodes ('R'/'W') used by the trace-driver front end
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StUpdate = 2'd2,
    StResp   = 2'd3
  } cache_state_e;

  typedef enum logic {
    WpThrough = 1'b0,
    WpBack    = 1'b1
  } write_policy_e;

  typedef enum logic {
    RpFifo = 1'b0,
    RpLru  = 1'b1
  } repl_policy_e;

  localparam int unsigned TagMaxW = 64;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TagMaxW-1:0] tag;
  } cache_line_t;

  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] OpWrite = 8'h57;

endpackage

// File: rtl/cache_sa_engine_if.sv
// Request/response bus of the cache engine, plus policy selects and traffic counters.
//  master : trace-driver side (drives request, policies, resp_ready)
//  slave  : engine side (drives req_ready, response fields, counters)
// Parameters must match those of the cache_sa_engine instance it connects to.
interface cache_sa_engine_if #(
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned NUM_SETS    = 64,
  parameter int unsigned CNT_W       = 16
);
  localparam int unsigned OffW = $clog2(BLOCK_BYTES);
  localparam int unsigned IdxW = $clog2(NUM_SETS);
  localparam int unsigned TagW = ADDR_W - IdxW - OffW;

  logic              write_policy;
  logic              replace_policy;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic              resp_evict;
  logic [TagW-1:0]   resp_evict_tag;
  logic              resp_evict_dirty;
  logic [IdxW-1:0]   resp_set;
  logic [CNT_W-1:0]  num_hits;
  logic [CNT_W-1:0]  num_misses;
  logic [CNT_W-1:0]  num_mem_reads;
  logic [CNT_W-1:0]  num_mem_writes;

  modport master (
    output write_policy, replace_policy, req_valid, req_addr, req_write, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_evict, resp_evict_tag, resp_evict_dirty,
           resp_set, num_hits, num_misses, num_mem_reads, num_mem_writes
  );

  modport slave (
    input  write_policy, replace_policy, req_valid, req_addr, req_write, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_evict, resp_evict_tag, resp_evict_dirty,
           resp_set, num_hits, num_misses, num_mem_reads, num_mem_writes
  );

endinterface

// File: rtl/cache_repl_order.sv
// Replacement-order helper for one set.
//  order_i[p]    : way id at age position p (0 = newest/MRU, ASSOC-1 = oldest/LRU)
//  valid_i       : per-way valid bits of the set
//  touched_way_i : way that was hit or allocated
//  is_miss_i     : request missed (touched way is the new allocation)
//  is_lru_i      : LRU policy (hits also refresh the order)
//  order_o       : order after the access
//  victim_o      : lowest-index invalid way, else the way at the oldest position
module cache_repl_order #(
  parameter int unsigned ASSOC = 2,
  parameter int unsigned WayW  = 1
) (
  input  logic [ASSOC-1:0][WayW-1:0] order_i,
  input  logic [ASSOC-1:0]           valid_i,
  input  logic [WayW-1:0]            touched_way_i,
  input  logic                       is_miss_i,
  input  logic                       is_lru_i,
  output logic [ASSOC-1:0][WayW-1:0] order_o,
  output logic [WayW-1:0]            victim_o
);

  always_comb begin
    victim_o = order_i[ASSOC-1];
    // Descending scan so the lowest invalid index wins.
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WayW'(w);
    end
  end

  // Move touched way to position 0; entries ahead of it slide one place older,
  // entries behind it keep their place. FIFO hits leave the order untouched.
  logic found;
  always_comb begin
    order_o = order_i;
    found   = 1'b0;
    if (is_miss_i || is_lru_i) begin
      order_o[0] = touched_way_i;
      for (int p = 1; p < ASSOC; p++) begin
        if (order_i[p-1] == touched_way_i) found = 1'b1;
        order_o[p] = found ? order_i[p] : order_i[p-1];
      end
    end
  end

endmodule

// File: rtl/cache_sa_engine.sv
// Set-associative cache tag/state engine: one address per handshake, lookup, replacement
// update and hit/evict report, with runtime FIFO/LRU and write-through/write-back.
// Ports:
//  clk   : clock
//  reset : synchronous, active-high; aborts any request in flight
//  bus   : cache_sa_engine_if.slave (request, response, policy selects, counters)
// Build option: CACHE_PERF_CNT_EN implements the four saturating traffic counters;
// without it the counter outputs are tied to zero.
module cache_sa_engine
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned NUM_SETS    = 64,
  parameter int unsigned ASSOC       = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic              clk,
  input logic              reset,
  cache_sa_engine_if.slave bus
);

  localparam int unsigned OffW = $clog2(BLOCK_BYTES);
  localparam int unsigned IdxW = $clog2(NUM_SETS);
  localparam int unsigned TagW = ADDR_W - IdxW - OffW;
  localparam int unsigned WayW = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  function automatic logic [ASSOC-1:0][WayW-1:0] reset_order();
    logic [ASSOC-1:0][WayW-1:0] o;
    for (int p = 0; p < ASSOC; p++) o[p] = WayW'(p);
    return o;
  endfunction

  cache_state_e  state_q, state_d;
  logic [TagW-1:0] req_tag_q;
  logic [IdxW-1:0] req_set_q;
  logic            req_write_q;
  write_policy_e   wp_q;
  repl_policy_e    rp_q;
  logic            hit_q;
  logic [WayW-1:0] way_q;

  logic [ASSOC-1:0]           valid_q [NUM_SETS];
  logic [ASSOC-1:0]           dirty_q [NUM_SETS];
  logic [TagW-1:0]            tag_q   [NUM_SETS][ASSOC];
  logic [ASSOC-1:0][WayW-1:0] order_q [NUM_SETS];

  logic            resp_hit_q, resp_evict_q, resp_evict_dirty_q;
  logic [TagW-1:0] resp_evict_tag_q;
  logic [IdxW-1:0] resp_set_q;

  logic unused_offset;
  assign unused_offset = ^bus.req_addr[OffW-1:0];

  logic accept;
  assign accept         = (state_q == StIdle) && bus.req_valid;
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.req_valid) state_d = StLookup;
      StLookup: state_d = StUpdate;
      StUpdate: state_d = StResp;
      StResp:   if (bus.resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Tag compare over the addressed set; lowest matching way wins.
  logic            lk_hit;
  logic [WayW-1:0] lk_hit_way;
  always_comb begin
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (valid_q[req_set_q][w] && (tag_q[req_set_q][w] == req_tag_q)) begin
        lk_hit     = 1'b1;
        lk_hit_way = WayW'(w);
      end
    end
  end

  logic [ASSOC-1:0][WayW-1:0] new_order;
  logic [WayW-1:0]            victim;

  cache_repl_order #(
    .ASSOC (ASSOC),
    .WayW  (WayW)
  ) u_repl_order (
    .order_i       (order_q[req_set_q]),
    .valid_i       (valid_q[req_set_q]),
    .touched_way_i (way_q),
    .is_miss_i     (!hit_q),
    .is_lru_i      (rp_q == RpLru),
    .order_o       (new_order),
    .victim_o      (victim)
  );

  // Set contents are unchanged between LOOKUP and UPDATE, so eviction facts are taken
  // directly from the selected way during UPDATE.
  logic ev, ev_dirty;
  assign ev       = !hit_q && valid_q[req_set_q][way_q];
  assign ev_dirty = ev && dirty_q[req_set_q][way_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      req_tag_q          <= '0;
      req_set_q          <= '0;
      req_write_q        <= 1'b0;
      wp_q               <= WpThrough;
      rp_q               <= RpFifo;
      hit_q              <= 1'b0;
      way_q              <= '0;
      resp_hit_q         <= 1'b0;
      resp_evict_q       <= 1'b0;
      resp_evict_dirty_q <= 1'b0;
      resp_evict_tag_q   <= '0;
      resp_set_q         <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        order_q[s] <= reset_order();
        for (int w = 0; w < ASSOC; w++) tag_q[s][w] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_tag_q   <= bus.req_addr[ADDR_W-1:IdxW+OffW];
        req_set_q   <= bus.req_addr[IdxW+OffW-1:OffW];
        req_write_q <= bus.req_write;
        wp_q        <= write_policy_e'(bus.write_policy);
        rp_q        <= repl_policy_e'(bus.replace_policy);
      end
      if (state_q == StLookup) begin
        hit_q <= lk_hit;
        way_q <= lk_hit ? lk_hit_way : victim;
      end
      if (state_q == StUpdate) begin
        if (!hit_q) begin
          // Write-allocate under both policies; only write-back marks the new line dirty.
          valid_q[req_set_q][way_q] <= 1'b1;
          tag_q[req_set_q][way_q]   <= req_tag_q;
          dirty_q[req_set_q][way_q] <= req_write_q && (wp_q == WpBack);
        end else if (req_write_q && (wp_q == WpBack)) begin
          dirty_q[req_set_q][way_q] <= 1'b1;
        end
        order_q[req_set_q] <= new_order;
        resp_hit_q         <= hit_q;
        resp_evict_q       <= ev;
        resp_evict_dirty_q <= ev_dirty;
        resp_evict_tag_q   <= ev ? tag_q[req_set_q][way_q] : '0;
        resp_set_q         <= req_set_q;
      end
    end
  end

  assign bus.resp_hit         = resp_hit_q;
  assign bus.resp_evict       = resp_evict_q;
  assign bus.resp_evict_dirty = resp_evict_dirty_q;
  assign bus.resp_evict_tag   = resp_evict_tag_q;
  assign bus.resp_set         = resp_set_q;

`ifdef CACHE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] v, logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W + 1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // A write-through write that also evicts a line dirtied earlier costs two memory writes.
  logic [1:0] mem_wr_inc;
  assign mem_wr_inc = {1'b0, req_write_q && (wp_q == WpThrough)} + {1'b0, ev_dirty};

  logic [CNT_W-1:0] hits_q, misses_q, mem_reads_q, mem_writes_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q       <= '0;
      misses_q     <= '0;
      mem_reads_q  <= '0;
      mem_writes_q <= '0;
    end else if (state_q == StUpdate) begin
      hits_q       <= sat_add(hits_q, {1'b0, hit_q});
      misses_q     <= sat_add(misses_q, {1'b0, !hit_q});
      mem_reads_q  <= sat_add(mem_reads_q, {1'b0, !hit_q});
      mem_writes_q <= sat_add(mem_writes_q, mem_wr_inc);
    end
  end

  assign bus.num_hits       = hits_q;
  assign bus.num_misses     = misses_q;
  assign bus.num_mem_reads  = mem_reads_q;
  assign bus.num_mem_writes = mem_writes_q;
`else
  assign bus.num_hits       = '0;
  assign bus.num_misses     = '0;
  assign bus.num_mem_reads  = '0;
  assign bus.num_mem_writes = '0;
`endif

endmodule
